// File: rtl/fifo_pkg.sv
// Shared constants, read-mode type and sizing helper for the parametrised FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

  // REG_READ: data registered one cycle after rd. FWFT: head word shown ahead.
  typedef enum logic {
    REG_READ = 1'b0,
    FWFT     = 1'b1
  } read_mode_e;

  // Pointer width for a power-of-two depth (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
// No reset; contents are only meaningful where the pointers say so.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port is combinational so a same-slot write returns the old word.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// selectable registered or first-word-fall-through read path.
//
// Handshake: wr/rd are requests sampled at the rising edge. A read is
// accepted when the FIFO is not empty; a write is accepted when it is not
// full, or when it is full and a read is accepted in the same cycle. A
// rejected request changes no state and raises overflow/underflow for the
// following cycle.
module sync_fifo_param #(
  parameter int WIDTH    = fifo_pkg::DEF_WIDTH,
  parameter int DEPTH    = fifo_pkg::DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  import fifo_pkg::*;

  localparam int AW = addr_w(DEPTH);
  localparam int CW = AW + 1;
  localparam read_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : REG_READ;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  // Parameter sanity: reject configurations the pointer/flag logic cannot honour.
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "sync_fifo_param: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_next;
  logic             full_q, empty_q, af_q, ae_q;
  logic             ovf_q, udf_q;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] mem_rdata;

  assign rd_acc = rd && !empty_q;
  assign wr_acc = wr && (!full_q || rd_acc);

  // Next occupancy from this cycle's accepted transfers.
  always_comb begin
    count_next = count_q;
    if (wr_acc && !rd_acc)      count_next = count_q + CW'(1);
    else if (!wr_acc && rd_acc) count_next = count_q - CW'(1);
  end

  // Pointers, count, flags and error pulses; flags track count_next so they
  // line up with count in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_next;
      full_q  <= (count_next == DEPTH_C);
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= AF_C);
      ae_q    <= (count_next <= AE_C);
      ovf_q   <= wr && !wr_acc;
      udf_q   <= rd && !rd_acc;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  if (MODE == REG_READ) begin : g_reg_read
    logic [WIDTH-1:0] rd_q;

    // Registered read: capture the head word on an accepted read, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rd_q <= '0;
      else if (rd_acc) rd_q <= mem_rdata;
    end

    assign rd_data = rd_q;
  end else begin : g_fwft_read
    // Show-ahead: head word visible whenever something is stored.
    assign rd_data = empty_q ? '0 : mem_rdata;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one FWFT instance share
// the same stimulus and are checked every cycle against a queue model.
module tb_sync_fifo_param;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr = 1'b0, rd = 1'b0;
  logic [W-1:0] wr_data = '0;

  logic [W-1:0] rd_data_r, rd_data_f;
  logic         full_r, empty_r, af_r, ae_r, ovf_r, udf_r;
  logic         full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [4:0]   count_r, count_f;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model state.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rd_reg = '0;
  logic         exp_ovf = 1'b0, exp_udf = 1'b0;
  bit           rd_ok, wr_ok;
  int           n_occ;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_reg (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .wr_data(wr_data),
    .rd_data(rd_data_r), .full(full_r), .empty(empty_r), .almost_full(af_r),
    .almost_empty(ae_r), .count(count_r), .overflow(ovf_r), .underflow(udf_r)
  );

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fw (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .wr_data(wr_data),
    .rd_data(rd_data_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(udf_f)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; returns 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d);
    wr = w; rd = r; wr_data = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  // Model: FIFO as a queue, rules applied to pre-edge occupancy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_rd_reg = '0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      rd_ok = rd && (exp_q.size() != 0);
      wr_ok = wr && ((exp_q.size() < D) || rd_ok);
      if (rd_ok) exp_rd_reg = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(wr_data);
      exp_ovf = wr && !wr_ok;
      exp_udf = rd && !rd_ok;
    end
  end

  // Scoreboard compare on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_occ = exp_q.size();
      chk("count_r", 32'(count_r), 32'(n_occ));
      chk("full_r", 32'(full_r), 32'(n_occ == D));
      chk("empty_r", 32'(empty_r), 32'(n_occ == 0));
      chk("af_r", 32'(af_r), 32'(n_occ >= AF));
      chk("ae_r", 32'(ae_r), 32'(n_occ <= AE));
      chk("ovf_r", 32'(ovf_r), 32'(exp_ovf));
      chk("udf_r", 32'(udf_r), 32'(exp_udf));
      chk("rd_data_r", 32'(rd_data_r), 32'(exp_rd_reg));
      chk("count_f", 32'(count_f), 32'(n_occ));
      chk("full_f", 32'(full_f), 32'(n_occ == D));
      chk("empty_f", 32'(empty_f), 32'(n_occ == 0));
      chk("af_f", 32'(af_f), 32'(n_occ >= AF));
      chk("ae_f", 32'(ae_f), 32'(n_occ <= AE));
      chk("ovf_f", 32'(ovf_f), 32'(exp_ovf));
      chk("udf_f", 32'(udf_f), 32'(exp_udf));
      chk("rd_data_f", 32'(rd_data_f), (n_occ != 0) ? 32'(exp_q[0]) : 32'h0);
    end
  end

  initial begin
    // Reset.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_count", 32'(count_r), 32'h0);
    chk("rst_empty", 32'(empty_r), 32'h1);
    chk("rst_ae", 32'(ae_r), 32'h1);
    chk("rst_full", 32'(full_r), 32'h0);
    chk("rst_rd_data", 32'(rd_data_r), 32'h0);

    // Fill with 0x0001..0x0010, flags against literal thresholds.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, W'(i));
      chk("t1_count", 32'(count_r), 32'(i));
      chk("t1_ae", 32'(ae_r), 32'(i <= 2));
      chk("t1_af", 32'(af_r), 32'(i >= 14));
      chk("t1_full", 32'(full_r), 32'(i == 16));
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, '0);
      chk("t1_rd", 32'(rd_data_r), 32'(i));
    end
    chk("t1_empty", 32'(empty_r), 32'h1);

    // Overflow on a full FIFO, underflow on an empty one.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 16'h0100 + W'(i));
    step(1'b1, 1'b0, 16'hBEEF);
    chk("t2_ovf", 32'(ovf_r), 32'h1);
    chk("t2_count", 32'(count_r), 32'd16);
    step(1'b0, 1'b0, '0);
    chk("t2_ovf_clr", 32'(ovf_r), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, '0);
      chk("t2_rd", 32'(rd_data_r), 32'(16'h0100 + i));
    end
    step(1'b0, 1'b1, '0);
    chk("t2_udf", 32'(udf_r), 32'h1);
    chk("t2_rd_hold", 32'(rd_data_r), 32'h0110);

    // Full FIFO, simultaneous read/write across pointer wrap.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 16'h0200 + W'(i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 16'hCAFE);
      chk("t3_count", 32'(count_r), 32'd16);
      chk("t3_ovf", 32'(ovf_r), 32'h0);
      chk("t3_rd", 32'(rd_data_r), (i < 16) ? 32'(16'h0201 + i) : 32'hCAFE);
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);

    // Empty FIFO, simultaneous read/write.
    step(1'b1, 1'b1, 16'h1234);
    chk("t4_udf", 32'(udf_r), 32'h1);
    chk("t4_count", 32'(count_r), 32'h1);
    step(1'b0, 1'b1, '0);
    chk("t4_rd", 32'(rd_data_r), 32'h1234);

    // Show-ahead visibility.
    wr = 1'b1; wr_data = 16'hA5A5;
    #2 chk("t5_pre", 32'(rd_data_f), 32'h0);
    @(posedge clk); #1;
    wr = 1'b0;
    chk("t5_show", 32'(rd_data_f), 32'hA5A5);
    step(1'b1, 1'b0, 16'hB6B6);
    chk("t5_keep", 32'(rd_data_f), 32'hA5A5);
    step(1'b0, 1'b1, '0);
    chk("t5_next", 32'(rd_data_f), 32'hB6B6);
    step(1'b0, 1'b1, '0);
    chk("t5_drained", 32'(rd_data_f), 32'h0);
    chk("t5_empty", 32'(empty_f), 32'h1);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, W'($urandom_range(1, 16'hFFFF)));
    step(1'b0, 1'b1, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_count", 32'(count_r), 32'h0);
    chk("t6_empty", 32'(empty_r), 32'h1);
    chk("t6_ae", 32'(ae_r), 32'h1);
    chk("t6_af", 32'(af_r), 32'h0);
    chk("t6_rd_r", 32'(rd_data_r), 32'h0);
    chk("t6_rd_f", 32'(rd_data_f), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h0077);
    step(1'b0, 1'b1, '0);
    chk("t6_rd", 32'(rd_data_r), 32'h0077);

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    for (int c = 0; c < 600; c++) begin
      int wp, rp;
      wp = ((c / 60) % 2 == 0) ? 75 : 30;
      rp = ((c / 60) % 2 == 0) ? 30 : 75;
      step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
           W'($urandom_range(0, 16'hFFFF)));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
